// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter that shares one resource (bus, memory port, ...) among
// N requesters. A rotating one-hot priority pointer marks where the next
// search starts. The grant is registered and one-hot. An owner keeps the grant
// while it keeps requesting. When someone else is waiting, an owner is limited
// to MAXHOLD consecutive cycles.
//
// Ports:
//   clk        in   1   clock, all state changes on the rising edge
//   reset      in   1   synchronous active-high reset, overrides en
//   en         in   1   advance enable; low freezes all state
//   req        in   N   request vector, bit i = requester i
//   gnt        out  N   registered one-hot grant, or all zero
//   gnt_valid  out  1   |gnt
//   gnt_id     out  W   binary index of the set gnt bit, 0 when gnt == 0
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N       = 4,
   parameter int W       = 2,
   parameter int MAXHOLD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_id
);

   localparam int CW = $clog2(MAXHOLD + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAXHOLD);
   localparam logic [N-1:0]  PTR_RST = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q;
   logic [N-1:0]    gnt_q;
   logic [N-1:0]    ptr_q;
   logic [CW-1:0]   cnt_q;

   logic [W-1:0]    ptr_idx;
   logic [W-1:0]    pos;
   logic            found;
   logic [N-1:0]    srch_oh;
   logic [N-1:0]    srch_rot;
   logic [W-1:0]    gnt_idx;
   logic            own_req;
   logic            others_w;
   logic            rel_w;

   // Binary position of the priority pointer; the search starts here.
   always_comb begin
      ptr_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (ptr_q[i]) ptr_idx = W'(i);
      end
   end

   // Circular first-one search from ptr upward, wrapping N-1 -> 0.
   always_comb begin
      srch_oh = '0;
      found   = 1'b0;
      pos     = '0;
      for (int o = 0; o < N; o++) begin
         pos = W'((int'(ptr_idx) + o) % N);
         if (!found && req[pos]) begin
            found        = 1'b1;
            srch_oh[pos] = 1'b1;
         end
      end
   end

   // The next pointer sits one past the new owner, so that owner drops to
   // lowest priority.
   assign srch_rot = {srch_oh[N-2:0], srch_oh[N-1]};

   // The owner releases when it stops requesting, or when its hold budget is
   // spent while somebody else is waiting. A sole requester never times out.
   assign own_req  = |(req & gnt_q);
   assign others_w = |(req & ~gnt_q);
   assign rel_w    = ~own_req | ((cnt_q == CNT_MAX) & others_w);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= PTR_RST;
         cnt_q   <= '0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt_q   <= srch_oh;
                  ptr_q   <= srch_rot;
                  cnt_q   <= CW'(1);
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!rel_w) begin
                  if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
               end else if (|req) begin
                  // Hand over on the same edge; no idle cycle in between.
                  gnt_q <= srch_oh;
                  ptr_q <= srch_rot;
                  cnt_q <= CW'(1);
               end else begin
                  gnt_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: begin
               gnt_q   <= '0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_q[i]) gnt_idx = W'(i);
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = gnt_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;
   localparam int N       = 4;
   localparam int W       = 2;
   localparam int MAXHOLD = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [W-1:0] gnt_id;

   rr_arbiter #(.N(N), .W(W), .MAXHOLD(MAXHOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] g;
      int           tag;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: who owns the resource (-1 = nobody), where the next
   // search begins, and how many consecutive cycles the owner has held it.
   int m_owner = -1;
   int m_start = 0;
   int m_hold  = 0;

   function automatic int find_next(input logic [N-1:0] r, input int start);
      for (int o = 0; o < N; o++) begin
         if (r[(start + o) % N]) return (start + o) % N;
      end
      return -1;
   endfunction

   task automatic give_to(input int k);
      m_owner = k;
      m_hold  = 1;
      m_start = (k + 1) % N;
   endtask

   task automatic model_step(input logic rst, input logic e, input logic [N-1:0] r);
      bit waiting;
      bit drop;
      if (rst) begin
         m_owner = -1;
         m_start = 0;
         m_hold  = 0;
      end else if (e) begin
         if (m_owner < 0) begin
            if (r != '0) give_to(find_next(r, m_start));
         end else begin
            waiting = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) waiting = 1'b1;
            drop = !r[m_owner] || (m_hold >= MAXHOLD && waiting);
            if (!drop) begin
               if (m_hold < MAXHOLD) m_hold++;
            end else if (r != '0) begin
               give_to(find_next(r, m_start));
            end else begin
               m_owner = -1;
            end
         end
      end
   endtask

   // One clock of stimulus. Directed cycles push the hand-written expectation
   // from the test plan; random cycles push the model's prediction.
   task automatic cycle(input logic rst, input logic e, input logic [N-1:0] r,
                        input bit directed, input logic [N-1:0] exp_g, input int tag);
      exp_t x;
      @(negedge clk);
      reset = rst;
      en    = e;
      req   = r;
      model_step(rst, e, r);
      x.tag = tag;
      if (directed) x.g = exp_g;
      else          x.g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      sbq.push_back(x);
   endtask

   // Monitor: after each rising edge, pop one expectation and compare.
   initial begin
      exp_t         x;
      logic [W-1:0] eid;
      forever begin
         @(posedge clk);
         #2;
         if (sbq.size() > 0) begin
            x   = sbq.pop_front();
            eid = '0;
            for (int i = 0; i < N; i++) if (x.g[i]) eid = W'(i);
            tests++;
            if (gnt !== x.g) begin
               fails++;
               $display("FAIL gnt tag=%0d actual=%b required=%b", x.tag, gnt, x.g);
            end
            tests++;
            if (gnt_valid !== (x.g != '0)) begin
               fails++;
               $display("FAIL gnt_valid tag=%0d actual=%b required=%b", x.tag, gnt_valid, (x.g != '0));
            end
            tests++;
            if (gnt_id !== eid) begin
               fails++;
               $display("FAIL gnt_id tag=%0d actual=%0d required=%0d", x.tag, gnt_id, eid);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] r;
      logic         e;
      logic         rs;

      reset = 1'b0;
      en    = 1'b1;
      req   = '0;

      // 1. Reset with everybody requesting, then release reset.
      cycle(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 100);
      cycle(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 101);
      // 2. Continuous all-ones: MAXHOLD cycles each, rotating.
      for (int i = 0; i < 20; i++)
         cycle(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001 << ((i / 4) % 4), 200 + i);

      // 3. Early release with handover, then drop to idle.
      cycle(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 300);
      cycle(1'b0, 1'b1, 4'b0101, 1'b1, 4'b0001, 301);
      cycle(1'b0, 1'b1, 4'b0101, 1'b1, 4'b0001, 302);
      cycle(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 303);
      cycle(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 304);
      cycle(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 305);
      cycle(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 306);

      // 4. Sole requester holds past MAXHOLD, then a wrapped handover.
      for (int i = 0; i < 12; i++)
         cycle(1'b0, 1'b1, 4'b0010, 1'b1, 4'b0010, 400 + i);
      cycle(1'b0, 1'b1, 4'b0011, 1'b1, 4'b0001, 412);
      cycle(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 413);

      // 5. Enable freeze in the middle of a hold.
      cycle(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 500);
      cycle(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 501);
      cycle(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 502);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b0, N'($urandom_range(0, 15)), 1'b1, 4'b0100, 503 + i);
      cycle(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 510);
      cycle(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 511);
      cycle(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1000, 512);

      // 6. Reset mid-grant, pointer returns to bit 0.
      cycle(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 600);
      cycle(1'b0, 1'b1, 4'b1001, 1'b1, 4'b0001, 601);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 49) == 0);
         e  = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 3))
            0:       r = 4'b1111;
            1:       r = N'(1) << $urandom_range(0, N - 1);
            default: r = N'($urandom_range(0, 15));
         endcase
         cycle(rs, e, r, 1'b0, '0, 1000 + i);
      end

      // Let the monitor drain; anything left over is a missed check.
      repeat (3) @(posedge clk);
      #3;
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain leftover=%0d required=0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Rotating one-hot priority pointer, in the same way as the team's ring counter.
- Registered one-hot grant. An owner may hold the grant while it keeps requesting, bounded by MAXHOLD cycles when others are waiting.
- Sits between requesting units and a shared datapath resource such as a bus or memory port.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 2, width of gnt_id; must satisfy 2^W >= N.
- MAXHOLD, 4, max consecutive cycles one owner keeps the grant while another requester is waiting (MAXHOLD >= 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset; overrides en.
- en  input  1  advance enable; when low, all state is frozen.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  registered one-hot grant, or all zero.
- gnt_valid  output  1  equals |gnt.
- gnt_id  output  W  binary index of the set gnt bit; 0 when gnt == 0.

Behaviour:
- State: FSM {IDLE, GRANT}; ptr[N-1:0] one-hot priority start; cnt, the hold counter, range 0..MAXHOLD.
- Reset (sync, active-high):
  - state = IDLE, gnt = 0, ptr = 1 (bit 0), cnt = 0.
  - gnt_valid = 0, gnt_id = 0 the cycle after reset is sampled.
  - Reset mid-grant drops the grant immediately with no completion.
- Search: select the first bit set in req, scanning circularly from the ptr position upward and wrapping from N-1 to 0. Combinational from req and ptr.
- Issuing a grant to owner k:
  - gnt <= one-hot(k), cnt <= 1.
  - ptr <= rotate-left(one-hot(k)), i.e. bit (k+1) mod N.
- en == 0: gnt, ptr, cnt and state all hold; req is ignored.
- IDLE, with en:
  - If |req, issue a grant from the search and go to GRANT.
  - Latency: req sampled in cycle t gives gnt visible in cycle t+1.
  - If req == 0, remain in IDLE with gnt = 0.
- GRANT, with en and owner k = gnt:
  - others = req & ~gnt.
  - release = ~req[k] | (cnt == MAXHOLD & |others).
  - No release: gnt holds; cnt <= min(cnt+1, MAXHOLD).
  - Release with any req bit set: issue a new grant from the search in the same edge, with no idle cycle.
    - ptr already points past k, so k is reselected only if it is the sole requester. This cannot occur on a timeout release.
  - Release with req == 0: gnt <= 0 and go to IDLE; ptr is unchanged.
- Sole requester:
  - Keeps the grant indefinitely; cnt saturates at MAXHOLD.
  - If another requester appears while cnt == MAXHOLD, release happens on that edge.
- Simultaneous events: an owner dropping req in the same cycle the timeout fires is a single release; the search starts from ptr.
- Invariants:
  - gnt is always 0 or one-hot.
  - ptr is always exactly one-hot.
  - gnt is only granted to a requester whose req was high at the sampling edge.
- gnt_id and gnt_valid are combinational decodes of the registered gnt, so there is no extra latency.
- Fairness: under continuous all-ones req, each requester gets exactly MAXHOLD cycles per rotation.

Test Plan (N=4, W=2, MAXHOLD=4):
1. Reset: reset=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, gnt_id=0; first cycle after reset falls -> gnt=0001, gnt_id=0.
2. Rotation: req=1111 held for 20 cycles -> gnt = 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001; gnt_id follows 0,1,2,3,0.
3. Early release: req=0101 and gnt=0001; req[0] drops at the 2nd grant cycle -> next cycle gnt=0100 with no zero cycle; when req becomes 0000 -> gnt=0000 next cycle, IDLE.
4. Sole requester: req=0010 for 12 cycles -> gnt=0010 every cycle with no gap past MAXHOLD; req becomes 0011 once cnt is saturated -> next cycle gnt=0001 (wrapped search from ptr=0100).
5. Enable freeze: gnt=0100 after 2 hold cycles, then en=0 for 5 cycles while req toggles -> gnt stays 0100; after en=1 with req=1111, 2 more cycles of 0100, then 1000.
6. Reset mid-grant: gnt=1000, reset pulse of 1 cycle -> gnt=0000 next cycle; then req=1001 -> gnt=0001 (ptr back at bit 0).
